// File: rtl/alu_seq.sv
// alu_seq -- registered, handshaked ALU with a sticky flag register.
//
// One operation is accepted per valid/ready handshake; the result, err and
// flags are held until the consumer takes them. Non-MUL operations complete
// on the accept edge. MUL runs a shift-add multiplier for WIDTH cycles in BUSY.
//
// Build option: define ALU_MUL_EN to implement MUL (opcode 0x05) and the BUSY
// state. Without it, 0x05 completes in one cycle as an invalid opcode.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (opcode, A, B)
//   opcode [7:0]          operation select
//   A, B [WIDTH-1:0]      operands (B is the shift amount for SHL/SHR)
//   out_valid / out_ready result handshake
//   Result [WIDTH-1:0]    registered result
//   err                   completed operation had an invalid opcode
//   Zero, Carry, Negative, Overflow  sticky flag register
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             err,
  output logic             Zero,
  output logic             Carry,
  output logic             Negative,
  output logic             Overflow
);

  localparam logic [7:0] OP_AND = 8'h00;
  localparam logic [7:0] OP_OR  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;
  localparam logic [7:0] OP_ADC = 8'h08;
  localparam logic [WIDTH:0] W_AMT = (WIDTH+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             err;
    logic             z;
    logic             c;
    logic             n;
    logic             v;
  } alu_t;

  // Two's-complement overflow for addition: same-sign operands, result flips sign.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Overflow for subtraction: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Single-cycle operations. Unknown opcodes (and MUL, which never reaches
  // here when the multiplier is built) give Result=0, err=1.
  function automatic alu_t alu_eval(input logic [7:0]       op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             cin);
    alu_t           r;
    logic [WIDTH:0] wide;
    logic           amt_ok;
    r      = '0;
    wide   = '0;
    amt_ok = (b != '0) && ({1'b0, b} <= W_AMT);
    case (op)
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = add_ovf(a, b, wide[WIDTH-1:0]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
        r.v   = sub_ovf(a, b, wide[WIDTH-1:0]);
      end
      OP_SHL: begin
        // the extra top bit catches the last bit shifted out
        if (b == '0) begin
          r.res = a;
        end else if (amt_ok) begin
          wide  = {1'b0, a} << b;
          r.res = wide[WIDTH-1:0];
          r.c   = wide[WIDTH];
        end
      end
      OP_SHR: begin
        if (b == '0) begin
          r.res = a;
        end else if (amt_ok) begin
          wide  = {a, 1'b0} >> b;
          r.res = wide[WIDTH:1];
          r.c   = wide[0];
        end
      end
      default: r.err = 1'b1;
    endcase
    r.z = (r.res == '0);
    r.n = r.res[WIDTH-1];
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [WIDTH-1:0] res_q;
  logic             err_q, z_q, c_q, n_q, v_q;
  logic             accept;
  logic             is_mul;
  alu_t             alu_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign Result    = res_q;
  assign err       = err_q;
  assign Zero      = z_q;
  assign Carry     = c_q;
  assign Negative  = n_q;
  assign Overflow  = v_q;

  always_comb alu_out = alu_eval(opcode, A, B, c_q);

`ifdef ALU_MUL_EN
  localparam logic [7:0] OP_MUL = 8'h05;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  assign is_mul   = (opcode == OP_MUL);
  assign mul_last = (state == BUSY) && (cnt == LAST);

  always_comb acc_nxt = mplier[0] ? (acc + mcand) : acc;

  // Multiplier datapath: one conditional add and shift per BUSY cycle
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = is_mul ? BUSY : DONE;
`ifdef ALU_MUL_EN
      BUSY: if (mul_last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result and flags load only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      err_q <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
`ifdef ALU_MUL_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        res_q <= alu_out.res;
        err_q <= alu_out.err;
        z_q   <= alu_out.z;
        c_q   <= alu_out.c;
        n_q   <= alu_out.n;
        v_q   <= alu_out.v;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (mul_last) begin
          res_q <= acc_nxt[WIDTH-1:0];
          err_q <= 1'b0;
          z_q   <= (acc_nxt[WIDTH-1:0] == '0);
          c_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
          n_q   <= acc_nxt[WIDTH-1];
          v_q   <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8. A table of operations with
// hand-computed results, flags and latency is applied in order (ADC carries
// depend on the previous entry), followed by hand-written sequences for output
// hold, ignored requests, and reset during DONE/BUSY.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] opcode = 8'h00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       err, zf, cf, nf, vf;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .err(err),
    .Zero(zf), .Carry(cf), .Negative(nf), .Overflow(vf)
  );

  always #5 clk = ~clk;

  // f = {err, Z, C, N, V}
  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] f;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " Result"}, 32'(result), 32'h00);
    chk({tag, " err+flags"}, 32'({err, zf, cf, nf, vf}), 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    edges;
    string tag;
    tag = $sformatf("vec%0d op%02h", idx, v.op);
    @(negedge clk);
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    opcode   = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    edges    = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      // scrambled operands must not disturb a captured operation
      in_valid = 1'b0;
      opcode   = 8'h02;
      a        = ~v.a;
      b        = ~v.b;
    end while (!out_valid && edges < 20);
    chk({tag, " latency"}, 32'(edges), 32'(v.lat));
    @(negedge clk);
    chk({tag, " Result"}, 32'(result), 32'(v.res));
    chk({tag, " err,Z,C,N,V"}, 32'({err, zf, cf, nf, vf}), 32'(v.f));
    chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " released"}, 32'({out_valid, in_ready}), 32'b01);
    chk({tag, " flags held"}, 32'({zf, cf, nf, vf}), 32'(v.f[3:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit   saw_valid;
    logic [12:0] snap;

    //                op     a      b      res     f(eZCNV)  lat
    tbl.push_back('{8'h02, 8'hFF, 8'h01, 8'h00, 5'b01100, 1});
    tbl.push_back('{8'h08, 8'h10, 8'h20, 8'h31, 5'b00000, 1});
    tbl.push_back('{8'h03, 8'h7F, 8'hFF, 8'h80, 5'b00111, 1});
    tbl.push_back('{8'h00, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1});
    tbl.push_back('{8'h01, 8'h0F, 8'hF0, 8'hFF, 5'b00010, 1});
    tbl.push_back('{8'h04, 8'hAA, 8'hAA, 8'h00, 5'b01000, 1});
    tbl.push_back('{8'h02, 8'h7F, 8'h01, 8'h80, 5'b00011, 1});
    tbl.push_back('{8'h08, 8'h01, 8'h01, 8'h02, 5'b00000, 1});
    tbl.push_back('{8'h02, 8'h80, 8'h80, 8'h00, 5'b01101, 1});
    tbl.push_back('{8'h08, 8'h00, 8'h00, 8'h01, 5'b00000, 1});
    tbl.push_back('{8'h06, 8'h81, 8'h01, 8'h02, 5'b00100, 1});
    tbl.push_back('{8'h08, 8'h00, 8'h00, 8'h01, 5'b00000, 1});
    tbl.push_back('{8'h07, 8'h81, 8'h08, 8'h00, 5'b01100, 1});
    tbl.push_back('{8'h06, 8'h81, 8'h09, 8'h00, 5'b01000, 1});
    tbl.push_back('{8'h06, 8'h81, 8'h00, 8'h81, 5'b00010, 1});
    tbl.push_back('{8'h07, 8'h81, 8'h01, 8'h40, 5'b00100, 1});
    tbl.push_back('{8'h06, 8'h81, 8'h08, 8'h00, 5'b01100, 1});
    tbl.push_back('{8'h08, 8'h7F, 8'h00, 8'h80, 5'b00011, 1});
    tbl.push_back('{8'h0F, 8'h12, 8'h34, 8'h00, 5'b11000, 1});
    tbl.push_back('{8'h03, 8'h05, 8'h03, 8'h02, 5'b00000, 1});
    tbl.push_back('{8'h03, 8'h03, 8'h05, 8'hFE, 5'b00110, 1});
`ifdef ALU_MUL_EN
    tbl.push_back('{8'h05, 8'h10, 8'h11, 8'h10, 5'b00100, 9});
    tbl.push_back('{8'h05, 8'h0F, 8'h0F, 8'hE1, 5'b00010, 9});
`else
    tbl.push_back('{8'h05, 8'h10, 8'h11, 8'h00, 5'b11000, 1});
    tbl.push_back('{8'h05, 8'h0F, 8'h0F, 8'h00, 5'b11000, 1});
`endif
    tbl.push_back('{8'h09, 8'h01, 8'h01, 8'h00, 5'b11000, 1});
    tbl.push_back('{8'h08, 8'h00, 8'h00, 8'h00, 5'b01000, 1});

    // reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // SUB held in DONE for 5 cycles while a new request is pending
    @(negedge clk);
    opcode = 8'h03; a = 8'h7F; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    opcode = 8'h02; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d state", i), 32'({out_valid, in_ready}), 32'b10);
      chk($sformatf("hold%0d Result", i), 32'(result), 32'h80);
      chk($sformatf("hold%0d err,Z,C,N,V", i), 32'({err, zf, cf, nf, vf}), 32'b00111);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold released", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk);
    @(negedge clk);
    chk("ignored request not queued", 32'(out_valid), 32'd0);
    chk("flags held in IDLE", 32'({zf, cf, nf, vf}), 32'b0111);

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    snap = {out_valid, in_ready, result, err, zf, cf};
    chk("out_ready idle ignored", 32'(snap), {19'd0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1});

    // reset while a result waits in DONE
    @(negedge clk);
    opcode = 8'h02; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset DONE", 32'({out_valid, zf, cf}), 32'b111);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset in DONE");

`ifdef ALU_MUL_EN
    // leave C,N set so the abort visibly clears them
    run_vec(100, '{8'h03, 8'h03, 8'h05, 8'hFE, 5'b00110, 1});
    @(negedge clk);
    opcode = 8'h05; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy in_ready", 32'({out_valid, in_ready}), 32'b00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset in BUSY");
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("aborted MUL emits nothing", 32'(saw_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
